// File: rtl/id_queue_decoder_pkg.sv
// Shared types, constants and immediate helper for the multi-lane decode queue.
package id_queue_decoder_pkg;

  localparam int ADDR_LEN = 32;
  localparam int ILEN     = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  typedef enum logic [1:0] {
    SRC_A_RS1, SRC_A_PC, SRC_A_ZERO
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR
  } src_b_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    RS_ALU, RS_LDST, RS_BRANCH, RS_MUL, RS_DIV
  } rs_ent_e;

  typedef enum logic [1:0] {
    DM_NONE, DM_LOAD, DM_LOADU, DM_STORE
  } dmem_type_e;

  typedef enum logic [1:0] {
    MD_MUL, MD_DIV, MD_REM
  } md_op_e;

  typedef enum logic {
    MD_OUT_LO, MD_OUT_HI
  } md_out_e;

  typedef struct packed {
    imm_type_e   imm_type;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    src_a_e      src_a_sel;
    src_b_e      src_b_sel;
    logic        wr_reg;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        illegal_instruction;
    alu_op_e     alu_op;
    rs_ent_e     rs_ent;
    logic [1:0]  dmem_size;
    dmem_type_e  dmem_type;
    md_op_e      md_req_op;
    logic        md_req_in_1_signed;
    logic        md_req_in_2_signed;
    md_out_e     md_req_out_sel;
  } dec_bundle_t;

  localparam int DEC_BUNDLE_WIDTH = $bits(dec_bundle_t);

  typedef struct packed {
    logic [ADDR_LEN-1:0] pc;
    logic [ILEN-1:0]     inst;
  } q_ent_t;

  function automatic logic [31:0] imm_decode(
    input logic [31:7] inst,
    input imm_type_e   t
  );
    logic [31:0] imm;
    case (t)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic alu_op_e alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_queue_decoder_lane.sv
// One decode lane: RV32IM decoder plus immediate generation, packed
// into a single bundle. Purely combinational.
module id_queue_decoder_lane
  import id_queue_decoder_pkg::*;
(
  input  logic [ILEN-1:0] inst_i,
  output dec_bundle_t     dec_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  dec_bundle_t d;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  always_comb begin
    d = '0;
    d.rs1            = inst_i[19:15];
    d.rs2            = inst_i[24:20];
    d.rd             = inst_i[11:7];
    d.imm_type       = IMM_NONE;
    d.src_a_sel      = SRC_A_RS1;
    d.src_b_sel      = SRC_B_IMM;
    d.alu_op         = ALU_ADD;
    d.rs_ent         = RS_ALU;
    d.dmem_type      = DM_NONE;
    d.md_req_op      = MD_MUL;
    d.md_req_out_sel = MD_OUT_LO;
    unique case (1'b1)
      (opc == OP_LUI): begin
        d.imm_type  = IMM_U;
        d.wr_reg    = 1'b1;
        d.src_a_sel = SRC_A_ZERO;
      end
      (opc == OP_AUIPC): begin
        d.imm_type  = IMM_U;
        d.wr_reg    = 1'b1;
        d.src_a_sel = SRC_A_PC;
      end
      (opc == OP_JAL): begin
        d.imm_type  = IMM_J;
        d.wr_reg    = 1'b1;
        d.src_a_sel = SRC_A_PC;
        d.src_b_sel = SRC_B_FOUR;
        d.rs_ent    = RS_BRANCH;
      end
      (opc == OP_JALR): begin
        d.imm_type  = IMM_I;
        d.wr_reg    = 1'b1;
        d.uses_rs1  = 1'b1;
        d.src_a_sel = SRC_A_PC;
        d.src_b_sel = SRC_B_FOUR;
        d.rs_ent    = RS_BRANCH;
        d.illegal_instruction = (f3 != 3'd0);
      end
      (opc == OP_BRANCH): begin
        d.imm_type  = IMM_B;
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
        d.src_b_sel = SRC_B_RS2;
        d.rs_ent    = RS_BRANCH;
        d.alu_op    = !f3[2] ? ALU_SUB :
                      (f3[1] ? ALU_SLTU : ALU_SLT);
        d.illegal_instruction = (f3[2:1] == 2'b01);
      end
      (opc == OP_LOAD): begin
        d.imm_type  = IMM_I;
        d.wr_reg    = 1'b1;
        d.uses_rs1  = 1'b1;
        d.rs_ent    = RS_LDST;
        d.dmem_size = f3[1:0];
        d.dmem_type = f3[2] ? DM_LOADU : DM_LOAD;
        d.illegal_instruction = (f3 == 3'd3) ||
                                (f3[2:1] == 2'b11);
      end
      (opc == OP_STORE): begin
        d.imm_type  = IMM_S;
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
        d.rs_ent    = RS_LDST;
        d.dmem_size = f3[1:0];
        d.dmem_type = DM_STORE;
        d.illegal_instruction = f3[2] || (f3[1:0] == 2'b11);
      end
      (opc == OP_IMM): begin
        d.imm_type = IMM_I;
        d.wr_reg   = 1'b1;
        d.uses_rs1 = 1'b1;
        d.alu_op   = alu_from_f3(f3, (f3 == 3'd5) && inst_i[30]);
        d.illegal_instruction =
          ((f3 == 3'd1) && (f7 != 7'h00)) ||
          ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      (opc == OP_REG): begin
        d.wr_reg    = 1'b1;
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
        d.src_b_sel = SRC_B_RS2;
        unique case (1'b1)
          (f7 == 7'h00): d.alu_op = alu_from_f3(f3, 1'b0);
          (f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)):
            d.alu_op = alu_from_f3(f3, 1'b1);
          (f7 == 7'h01): begin
            d.rs_ent    = f3[2] ? RS_DIV : RS_MUL;
            d.md_req_op = !f3[2] ? MD_MUL :
                          (f3[1] ? MD_REM : MD_DIV);
            d.md_req_out_sel = (!f3[2] && (f3[1:0] != 2'b00)) ?
                               MD_OUT_HI : MD_OUT_LO;
            d.md_req_in_1_signed = f3[2] ? !f3[0] :
                                   (f3[1:0] != 2'b11);
            d.md_req_in_2_signed = f3[2] ? !f3[0] : !f3[1];
          end
          default: d.illegal_instruction = 1'b1;
        endcase
      end
      default: d.illegal_instruction = 1'b1;
    endcase
    // Illegal ops must not claim registers or carry a stray immediate.
    if (d.illegal_instruction) begin
      d.imm_type = IMM_NONE;
      d.wr_reg   = 1'b0;
      d.uses_rs1 = 1'b0;
      d.uses_rs2 = 1'b0;
    end
    d.imm = imm_decode(inst_i[31:7], d.imm_type);
  end

  assign dec_o = d;

endmodule

// File: rtl/id_queue_decoder.sv
// Multi-lane decode stage: circular instruction queue fed by fetch,
// DECODE_WIDTH head entries decoded and registered toward dispatch.
module id_queue_decoder
  import id_queue_decoder_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [FETCH_WIDTH-1:0]                 in_valid_i,
  input  logic [FETCH_WIDTH*ILEN-1:0]            in_inst_i,
  input  logic [FETCH_WIDTH*ADDR_LEN-1:0]        in_pc_i,
  output logic                                   in_ready_o,
  input  logic                                   stall_DP,
  input  logic                                   kill_ID,
  output logic [DECODE_WIDTH-1:0]                out_valid_o,
  output logic [DECODE_WIDTH*ADDR_LEN-1:0]       out_pc_o,
  output logic [DECODE_WIDTH*DEC_BUNDLE_WIDTH-1:0] out_dec_o,
  output logic [$clog2(DEPTH):0]                 count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OPW = DECODE_WIDTH * ADDR_LEN;
  localparam int ODW = DECODE_WIDTH * DEC_BUNDLE_WIDTH;

  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  q_ent_t         mem_q [DEPTH];
  q_ent_t         mem_d [DEPTH];

  logic [DECODE_WIDTH-1:0] out_valid_q, out_valid_d;
  logic [OPW-1:0]          out_pc_q, out_pc_d;
  logic [ODW-1:0]          out_dec_q, out_dec_d;

  logic           push_en;
  logic [CW-1:0]  n_push;
  logic [CW-1:0]  n_pop;

  logic [ADDR_LEN-1:0] lane_pc  [DECODE_WIDTH];
  dec_bundle_t         lane_dec [DECODE_WIDTH];

  assign in_ready_o = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);
  assign push_en    = in_ready_o && in_valid_i[0] && !kill_ID;

  // Only the leading run of valid lanes is accepted.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (push_en && in_valid_i[k] && (n_push == CW'(k)))
        n_push = CW'(k + 1);
    end
  end

  always_comb begin
    n_pop = (count_q < CW'(DECODE_WIDTH)) ?
            count_q : CW'(DECODE_WIDTH);
    if (stall_DP || kill_ID)
      n_pop = '0;
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (CW'(k) < n_push) begin
        mem_d[tail_q + PW'(k)] = '{
          pc:   in_pc_i[k*ADDR_LEN +: ADDR_LEN],
          inst: in_inst_i[k*ILEN +: ILEN]
        };
      end
    end
  end

  always_comb begin
    head_d  = head_q + PW'(n_pop);
    tail_d  = tail_q + PW'(n_push);
    count_d = count_q + n_push - n_pop;
    if (kill_ID) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_lane
    q_ent_t ent;
    assign ent        = mem_q[head_q + PW'(j)];
    assign lane_pc[j] = ent.pc;
    id_queue_decoder_lane u_decode_lane (
      .inst_i (ent.inst),
      .dec_o  (lane_dec[j])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_dec_d   = out_dec_q;
    if (kill_ID) begin
      out_valid_d = '0;
      out_pc_d    = '0;
      out_dec_d   = '0;
    end else if (!stall_DP) begin
      for (int j = 0; j < DECODE_WIDTH; j++) begin
        out_valid_d[j] = CW'(j) < n_pop;
        out_pc_d[j*ADDR_LEN +: ADDR_LEN] = lane_pc[j];
        out_dec_d[j*DEC_BUNDLE_WIDTH +: DEC_BUNDLE_WIDTH] = lane_dec[j];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= '0;
      out_pc_q    <= '0;
      out_dec_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_dec_q   <= out_dec_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign out_valid_o = out_valid_q;
  assign out_pc_o    = out_pc_q;
  assign out_dec_o   = out_dec_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_id_queue_decoder.sv
// Randomized bench for id_queue_decoder against a queue-level
// reference model with an ISA-level decode reference.
module tb_id_queue_decoder;
  import id_queue_decoder_pkg::*;

  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 8;
  localparam int BW    = DEC_BUNDLE_WIDTH;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic [FW-1:0]        in_valid_i;
  logic [FW*32-1:0]     in_inst_i;
  logic [FW*32-1:0]     in_pc_i;
  logic                 in_ready_o;
  logic                 stall_DP;
  logic                 kill_ID;
  logic [DW-1:0]        out_valid_o;
  logic [DW*32-1:0]     out_pc_o;
  logic [DW*BW-1:0]     out_dec_o;
  logic [3:0]           count_o;

  always #5 clk_i = ~clk_i;

  id_queue_decoder #(
    .FETCH_WIDTH  (FW),
    .DECODE_WIDTH (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_inst_i   (in_inst_i),
    .in_pc_i     (in_pc_i),
    .in_ready_o  (in_ready_o),
    .stall_DP    (stall_DP),
    .kill_ID     (kill_ID),
    .out_valid_o (out_valid_o),
    .out_pc_o    (out_pc_o),
    .out_dec_o   (out_dec_o),
    .count_o     (count_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic        m_valid [DW];
  logic [31:0] m_pc    [DW];
  logic [31:0] m_inst  [DW];
  bit          m_clear;
  logic [31:0] pc_ctr;

  function automatic void ref_dec(input logic [31:0] i,
    output logic ill, output logic [31:0] imm,
    output logic wr, output logic u1, output logic u2);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    ill = 0; wr = 0; u1 = 0; u2 = 0; imm = 0;
    case (i[6:0])
      7'h37, 7'h17: begin wr = 1; imm = {i[31:12], 12'h000}; end
      7'h6f: begin
        wr = 1;
        imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h67: begin
        ill = (f3 != 0); wr = 1; u1 = 1;
        imm = {{20{i[31]}}, i[31:20]};
      end
      7'h63: begin
        ill = (f3 == 2) || (f3 == 3); u1 = 1; u2 = 1;
        imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h03: begin
        ill = (f3 == 3) || (f3 >= 6); wr = 1; u1 = 1;
        imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: begin
        ill = (f3 >= 3); u1 = 1; u2 = 1;
        imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h13: begin
        ill = ((f3 == 1) && (f7 != 0)) ||
              ((f3 == 5) && (f7 != 0) && (f7 != 7'h20));
        wr = 1; u1 = 1;
        imm = {{20{i[31]}}, i[31:20]};
      end
      7'h33: begin
        ill = !((f7 == 0) || (f7 == 1) ||
                ((f7 == 7'h20) && ((f3 == 0) || (f3 == 5))));
        wr = 1; u1 = 1; u2 = 1;
      end
      default: ill = 1;
    endcase
    if (ill) begin
      wr = 0; u1 = 0; u2 = 0; imm = 0;
    end
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    int sel;
    r = $urandom();
    sel = $urandom_range(0, 10);
    case (sel)
      0: r[6:0] = 7'h37;
      1: r[6:0] = 7'h17;
      2: r[6:0] = 7'h6f;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h03;
      6: r[6:0] = 7'h23;
      7: r[6:0] = 7'h13;
      8: r[6:0] = 7'h33;
      9: begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic dec_bundle_t lane(input int j);
    return dec_bundle_t'(out_dec_o[j*BW +: BW]);
  endfunction

  task automatic compare_all();
    dec_bundle_t b;
    logic ill, wr, u1, u2;
    logic [31:0] imm;
    int sz;
    sz = mq_pc.size();
    check("count", 64'(count_o), 64'(sz));
    check("ready", 64'(in_ready_o), 64'((DEPTH - sz) >= FW));
    for (int j = 0; j < DW; j++)
      check($sformatf("valid%0d", j), 64'(out_valid_o[j]),
            64'(m_valid[j]));
    if (m_clear) begin
      check("zero_pc", 64'(out_pc_o == '0), 64'(1));
      check("zero_dec", 64'(out_dec_o == '0), 64'(1));
    end
    for (int j = 0; j < DW; j++) begin
      if (m_valid[j]) begin
        b = lane(j);
        ref_dec(m_inst[j], ill, imm, wr, u1, u2);
        check($sformatf("pc%0d", j), 64'(out_pc_o[j*32 +: 32]),
              64'(m_pc[j]));
        check($sformatf("rd%0d", j), 64'(b.rd), 64'(m_inst[j][11:7]));
        check($sformatf("rs1_%0d", j), 64'(b.rs1),
              64'(m_inst[j][19:15]));
        check($sformatf("rs2_%0d", j), 64'(b.rs2),
              64'(m_inst[j][24:20]));
        check($sformatf("imm%0d", j), 64'(b.imm), 64'(imm));
        check($sformatf("ill%0d", j), 64'(b.illegal_instruction),
              64'(ill));
        check($sformatf("wr%0d", j), 64'(b.wr_reg), 64'(wr));
        check($sformatf("u1_%0d", j), 64'(b.uses_rs1), 64'(u1));
        check($sformatf("u2_%0d", j), 64'(b.uses_rs2), 64'(u2));
      end
    end
  endtask

  task automatic step(input bit rst, input bit kill, input bit stall,
                      input logic [FW-1:0] vm,
                      input logic [31:0] i0, input logic [31:0] i1);
    int np, npop;
    bit rdy;
    reset_i    = rst;
    kill_ID    = kill;
    stall_DP   = stall;
    in_valid_i = vm;
    in_inst_i  = {i1, i0};
    in_pc_i    = {pc_ctr + 32'd4, pc_ctr};
    if (rst || kill) begin
      mq_pc.delete();
      mq_inst.delete();
      for (int j = 0; j < DW; j++) m_valid[j] = 1'b0;
      m_clear = 1;
      if (rst) pc_ctr = 0;
    end else begin
      rdy = (DEPTH - mq_pc.size()) >= FW;
      np = 0;
      if (rdy) begin
        for (int k = 0; k < FW; k++) begin
          if (!vm[k]) break;
          np++;
        end
      end
      if (!stall) begin
        npop = (mq_pc.size() < DW) ? mq_pc.size() : DW;
        m_clear = 0;
        for (int j = 0; j < DW; j++) begin
          m_valid[j] = (j < npop);
          if (j < npop) begin
            m_pc[j]   = mq_pc.pop_front();
            m_inst[j] = mq_inst.pop_front();
          end
        end
      end
      for (int k = 0; k < np; k++) begin
        mq_pc.push_back(pc_ctr + 32'(4 * k));
        mq_inst.push_back(k == 0 ? i0 : i1);
      end
      pc_ctr += 32'(4 * np);
    end
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic idle(input bit stall);
    step(0, 0, stall, '0, rnd_inst(), rnd_inst());
  endtask

  task automatic push2(input bit stall);
    step(0, 0, stall, 2'b11, rnd_inst(), rnd_inst());
  endtask

  initial begin
    dec_bundle_t b0, b1;
    logic [31:0] exp_pc;
    reset_i = 1; kill_ID = 0; stall_DP = 0;
    in_valid_i = 0; in_inst_i = 0; in_pc_i = 0;
    pc_ctr = 0;
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    check("rst_ready", 64'(in_ready_o), 64'(1));

    // ADDI x1,x0,5 / ADD x2,x1,x1
    step(0, 0, 0, 2'b11, 32'h00500093, 32'h00108133);
    idle(0);
    b0 = lane(0);
    b1 = lane(1);
    check("t1_valid", 64'(out_valid_o), 64'(2'b11));
    check("t1_rd", 64'(b0.rd), 64'(1));
    check("t1_imm", 64'(b0.imm), 64'(5));
    check("t1_rs1", 64'(b1.rs1), 64'(1));
    check("t1_rs2", 64'(b1.rs2), 64'(1));
    check("t1_count", 64'(count_o), 64'(0));

    // Fill under stall, then drain in order.
    step(1, 0, 0, '0, 0, 0);
    repeat (4) push2(1);
    check("t2_full", 64'(count_o), 64'(8));
    check("t2_ready", 64'(in_ready_o), 64'(0));
    exp_pc = 0;
    repeat (4) begin
      idle(0);
      check("t2_pc0", 64'(out_pc_o[31:0]), 64'(exp_pc));
      check("t2_pc1", 64'(out_pc_o[63:32]), 64'(exp_pc + 4));
      exp_pc += 8;
    end
    check("t2_empty", 64'(count_o), 64'(0));

    // Streaming across several wrap-arounds.
    step(1, 0, 0, '0, 0, 0);
    exp_pc = 0;
    repeat (22) begin
      push2(0);
      for (int j = 0; j < DW; j++) begin
        if (out_valid_o[j]) begin
          check("t3_seq", 64'(out_pc_o[j*32 +: 32]), 64'(exp_pc));
          exp_pc += 4;
        end
      end
    end
    check("t3_total", 64'(exp_pc), 64'(4 * 42));

    // Single-lane push.
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 1, 2'b01, rnd_inst(), rnd_inst());
    step(0, 0, 1, 2'b01, rnd_inst(), rnd_inst());
    check("t4_count", 64'(count_o), 64'(2));
    idle(0);
    check("t4_v11", 64'(out_valid_o), 64'(2'b11));
    idle(0);
    check("t4_v00", 64'(out_valid_o), 64'(2'b00));

    // Kill with a concurrent push.
    step(1, 0, 0, '0, 0, 0);
    push2(1);
    push2(1);
    step(0, 0, 1, 2'b01, rnd_inst(), rnd_inst());
    check("t5_count5", 64'(count_o), 64'(5));
    step(0, 1, 0, 2'b11, rnd_inst(), rnd_inst());
    check("t5_count0", 64'(count_o), 64'(0));
    check("t5_valid0", 64'(out_valid_o), 64'(0));
    idle(0);
    idle(0);
    check("t5_absent", 64'(out_valid_o), 64'(0));

    // Stall hold and reset mid-stall.
    step(1, 0, 0, '0, 0, 0);
    push2(1);
    push2(1);
    idle(0);
    check("t6_v11", 64'(out_valid_o), 64'(2'b11));
    repeat (3) begin
      idle(1);
      check("t6_pc0", 64'(out_pc_o[31:0]), 64'(0));
      check("t6_pc1", 64'(out_pc_o[63:32]), 64'(4));
      check("t6_cnt", 64'(count_o), 64'(2));
    end
    step(1, 0, 1, '0, 0, 0);
    check("t6_rst_v", 64'(out_valid_o), 64'(0));
    check("t6_rst_pc", 64'(out_pc_o), 64'(0));

    // Random traffic.
    repeat (400) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) == 0,
           FW'($urandom_range(0, 3)),
           rnd_inst(), rnd_inst());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
